alu_ctrl_stage: RTL and testbench

Registered ALU-control decode stage. It accepts a 32-bit MIPS instruction over a valid/ready handshake and decodes opcode/funct into the 6-bit ALU function code. That code's low 4 bits are the logic-unit FLAG encoding. The stage also produces operand-select controls and the extended immediate, and presents them to the execute stage through a one-entry output register with stall and flush.

---
 rtl/alu_ctrl_if.sv | 28 ++
 rtl/alu_ctrl_stage.sv | 163 ++++++++++++++++
 tb/tb_alu_ctrl_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_if.sv
// rtl/alu_ctrl_if.sv - handshake and decoded-control bundle for alu_ctrl_stage
interface alu_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  alu_fun;
   logic        sign;
   logic        src1_shamt;
   logic        src2_imm;
   logic [31:0] imm_ext;
   logic [4:0]  shamt;
   logic        illegal;

   modport slave (
      input  in_valid, instr, flush, out_ready,
      output in_ready, out_valid, alu_fun, sign, src1_shamt, src2_imm,
             imm_ext, shamt, illegal
   );

   modport master (
      output in_valid, instr, flush, out_ready,
      input  in_ready, out_valid, alu_fun, sign, src1_shamt, src2_imm,
             imm_ext, shamt, illegal
   );
endinterface

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - MIPS opcode/funct to ALU control decode with one-entry output register
module alu_ctrl_stage #(
   parameter logic [5:0] ILLEGAL_FUN = 6'b011010
) (
   input  logic        clk,
   input  logic        reset,
   alu_ctrl_if.slave   bus
);
   localparam logic [5:0] F_ADD = 6'b000000, F_SUB = 6'b000001;
   localparam logic [5:0] F_AND = 6'b011000, F_OR  = 6'b011110;
   localparam logic [5:0] F_XOR = 6'b010110, F_NOR = 6'b010001;
   localparam logic [5:0] F_SLL = 6'b100000, F_SRL = 6'b100001, F_SRA = 6'b100011;
   localparam logic [5:0] F_EQ  = 6'b110011, F_NEQ = 6'b110001, F_LT  = 6'b110101;
   localparam logic [5:0] F_LEZ = 6'b111101, F_LTZ = 6'b111011, F_GTZ = 6'b111111;

   typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_UPPER} ext_e;

   logic [5:0]  opcode, funct;
   logic [4:0]  rt;
   logic [15:0] imm;
   assign opcode = bus.instr[31:26];
   assign funct  = bus.instr[5:0];
   assign rt     = bus.instr[20:16];
   assign imm    = bus.instr[15:0];

   logic [5:0]  dec_fun;
   logic        dec_sign, dec_s1, dec_s2, dec_ill;
   logic [31:0] dec_imm;
   ext_e        dec_ext;

   always_comb begin
      dec_fun  = ILLEGAL_FUN;
      dec_sign = 1'b0;
      dec_s1   = 1'b0;
      dec_s2   = 1'b0;
      dec_ill  = 1'b1;
      dec_ext  = EXT_SIGN;
      dec_imm  = 32'h0;
      case (opcode)
         6'h00: begin
            dec_ill = 1'b0;
            case (funct)
               6'h20, 6'h21, 6'h08, 6'h09: begin dec_fun = F_ADD; dec_sign = (funct == 6'h20); end
               6'h22, 6'h23: begin dec_fun = F_SUB; dec_sign = (funct == 6'h22); end
               6'h24: dec_fun = F_AND;
               6'h25: dec_fun = F_OR;
               6'h26: dec_fun = F_XOR;
               6'h27: dec_fun = F_NOR;
               6'h00: begin dec_fun = F_SLL; dec_s1 = 1'b1; end
               6'h02: begin dec_fun = F_SRL; dec_s1 = 1'b1; end
               6'h03: begin dec_fun = F_SRA; dec_s1 = 1'b1; end
               6'h2A, 6'h2B: begin dec_fun = F_LT; dec_sign = (funct == 6'h2A); end
               default: dec_ill = 1'b1;
            endcase
         end
         6'h08, 6'h09: begin dec_fun = F_ADD; dec_s2 = 1'b1; dec_ill = 1'b0; dec_sign = (opcode == 6'h08); end
         6'h0C: begin dec_fun = F_AND; dec_s2 = 1'b1; dec_ill = 1'b0; dec_ext = EXT_ZERO; end
         6'h0D: begin dec_fun = F_OR;  dec_s2 = 1'b1; dec_ill = 1'b0; dec_ext = EXT_ZERO; end
         6'h0E: begin dec_fun = F_XOR; dec_s2 = 1'b1; dec_ill = 1'b0; dec_ext = EXT_ZERO; end
         6'h0F: begin dec_fun = F_OR;  dec_s2 = 1'b1; dec_ill = 1'b0; dec_ext = EXT_UPPER; end
         6'h0A, 6'h0B: begin dec_fun = F_LT; dec_s2 = 1'b1; dec_ill = 1'b0; dec_sign = (opcode == 6'h0A); end
         6'h23, 6'h2B: begin dec_fun = F_ADD; dec_s2 = 1'b1; dec_ill = 1'b0; end
         6'h04: begin dec_fun = F_EQ;  dec_sign = 1'b1; dec_ill = 1'b0; end
         6'h05: begin dec_fun = F_NEQ; dec_sign = 1'b1; dec_ill = 1'b0; end
         6'h06: begin dec_fun = F_LEZ; dec_sign = 1'b1; dec_ill = 1'b0; end
         6'h07: begin dec_fun = F_GTZ; dec_sign = 1'b1; dec_ill = 1'b0; end
         // REGIMM: only bltz (rt=0) is supported
         6'h01: begin
            if (rt == 5'd0) begin
               dec_fun  = F_LTZ;
               dec_sign = 1'b1;
               dec_ill  = 1'b0;
            end
         end
         6'h02, 6'h03: begin dec_fun = F_ADD; dec_ill = 1'b0; end
         default: ;
      endcase
      // an undecodable entry must carry no operand selects or immediate
      if (dec_ill) begin
         dec_fun  = ILLEGAL_FUN;
         dec_sign = 1'b0;
         dec_s1   = 1'b0;
         dec_s2   = 1'b0;
      end else begin
         case (dec_ext)
            EXT_ZERO:  dec_imm = {16'h0, imm};
            EXT_UPPER: dec_imm = {imm, 16'h0};
            default:   dec_imm = {{16{imm[15]}}, imm};
         endcase
      end
   end

   logic        out_valid_q, out_valid_d;
   logic [5:0]  alu_fun_q, alu_fun_d;
   logic        sign_q, sign_d;
   logic        src1_shamt_q, src1_shamt_d;
   logic        src2_imm_q, src2_imm_d;
   logic [31:0] imm_ext_q, imm_ext_d;
   logic [4:0]  shamt_q, shamt_d;
   logic        illegal_q, illegal_d;
   logic        in_ready, accept, consume;

   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   assign consume  = out_valid_q && bus.out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      alu_fun_d    = alu_fun_q;
      sign_d       = sign_q;
      src1_shamt_d = src1_shamt_q;
      src2_imm_d   = src2_imm_q;
      imm_ext_d    = imm_ext_q;
      shamt_d      = shamt_q;
      illegal_d    = illegal_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d  = 1'b1;
         alu_fun_d    = dec_fun;
         sign_d       = dec_sign;
         src1_shamt_d = dec_s1;
         src2_imm_d   = dec_s2;
         imm_ext_d    = dec_imm;
         shamt_d      = bus.instr[10:6];
         illegal_d    = dec_ill;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         alu_fun_q    <= ILLEGAL_FUN;
         sign_q       <= 1'b0;
         src1_shamt_q <= 1'b0;
         src2_imm_q   <= 1'b0;
         imm_ext_q    <= 32'h0;
         shamt_q      <= 5'd0;
         illegal_q    <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         alu_fun_q    <= alu_fun_d;
         sign_q       <= sign_d;
         src1_shamt_q <= src1_shamt_d;
         src2_imm_q   <= src2_imm_d;
         imm_ext_q    <= imm_ext_d;
         shamt_q      <= shamt_d;
         illegal_q    <= illegal_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.alu_fun    = alu_fun_q;
   assign bus.sign       = sign_q;
   assign bus.src1_shamt = src1_shamt_q;
   assign bus.src2_imm   = src2_imm_q;
   assign bus.imm_ext    = imm_ext_q;
   assign bus.shamt      = shamt_q;
   assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - scoreboard bench for alu_ctrl_stage
module tb_alu_ctrl_stage;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_ctrl_if bus ();
   alu_ctrl_stage dut (.clk(clk), .reset(reset), .bus(bus));

   int tests = 0;
   int fails = 0;
   logic [46:0] q[$];
   logic [46:0] cur_exp;
   bit exp_valid = 1'b0;
   bit last_accept;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [46:0] ex(input logic [5:0] fun, input logic sg, input logic s1,
                                       input logic s2, input logic [31:0] im, input logic [4:0] sh,
                                       input logic ill);
      return {ill, fun, sg, s1, s2, im, sh};
   endfunction

   function automatic logic [46:0] obs();
      return {bus.illegal, bus.alu_fun, bus.sign, bus.src1_shamt, bus.src2_imm, bus.imm_ext, bus.shamt};
   endfunction

   // one clock: check against the handshake model at negedge, then step past the edge
   task automatic tick();
      logic acc;
      @(negedge clk);
      last_accept = 1'b0;
      if (reset) begin
         q.delete();
         exp_valid = 1'b0;
      end else begin
         check_eq("out_valid", bus.out_valid, exp_valid);
         check_eq("in_ready", bus.in_ready, !exp_valid || bus.out_ready);
         acc = bus.in_valid && (!exp_valid || bus.out_ready);
         last_accept = acc;
         if (exp_valid) begin
            check_eq("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
               check_eq("entry", obs(), q[0]);
               if (bus.out_ready || bus.flush) void'(q.pop_front());
            end
         end
         if (acc && !bus.flush) q.push_back(cur_exp);
         if (bus.flush)                     exp_valid = 1'b0;
         else if (acc)                      exp_valid = 1'b1;
         else if (exp_valid && bus.out_ready) exp_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [46:0] e);
      int n;
      bus.instr = ins;
      bus.in_valid = 1'b1;
      cur_exp = e;
      n = 0;
      do begin
         tick();
         n++;
      end while (!last_accept && n < 20);
      if (!last_accept) check_eq("accept_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b1;
      bus.instr = 32'h00851024;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      cur_exp = '0;
      tick();
      tick();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      #2;
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_alu_fun", bus.alu_fun, 6'b011010);
      check_eq("rst_in_ready", bus.in_ready, 1);
      check_eq("rst_fields", obs(), ex(6'b011010, 0, 0, 0, 32'h0, 5'd0, 0));
      idle(1);

      // back-to-back stream
      send(32'h00851024, ex(6'b011000, 0, 0, 0, 32'h00001024, 5'd0, 0));
      send(32'h3484FFFF, ex(6'b011110, 0, 0, 1, 32'h0000FFFF, 5'd31, 0));
      send(32'h00042080, ex(6'b100000, 0, 1, 0, 32'h00002080, 5'd2, 0));
      idle(2);

      // stall with a new instruction waiting
      bus.out_ready = 1'b0;
      send(32'h2084FFFF, ex(6'b000000, 1, 0, 1, 32'hFFFFFFFF, 5'd31, 0));
      bus.instr = 32'h3C041234;
      bus.in_valid = 1'b1;
      cur_exp = ex(6'b011110, 0, 0, 1, 32'h12340000, 5'd8, 0);
      for (int i = 0; i < 3; i++) tick();
      bus.out_ready = 1'b1;
      send(32'h3C041234, ex(6'b011110, 0, 0, 1, 32'h12340000, 5'd8, 0));
      idle(2);

      // flush drops a same-cycle accept
      bus.flush = 1'b1;
      send(32'h10850003, ex(6'b110011, 1, 0, 0, 32'h00000003, 5'd0, 0));
      bus.flush = 1'b0;
      send(32'h14850003, ex(6'b110001, 1, 0, 0, 32'h00000003, 5'd0, 0));
      idle(2);

      // reset during a stall discards the held entry
      bus.out_ready = 1'b0;
      send(32'h8C85FFFC, ex(6'b000000, 0, 0, 1, 32'hFFFFFFFC, 5'd31, 0));
      bus.in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      idle(1);

      // illegal encodings and remaining classes
      send(32'hFC000000, ex(6'b011010, 0, 0, 0, 32'h0, 5'd0, 1));
      send(32'h04A10001, ex(6'b011010, 0, 0, 0, 32'h0, 5'd0, 1));
      send(32'h04A00001, ex(6'b111011, 1, 0, 0, 32'h00000001, 5'd0, 0));
      send(32'h00A4082A, ex(6'b110101, 1, 0, 0, 32'h0000082A, 5'd0, 0));
      send(32'h8C85FFFC, ex(6'b000000, 0, 0, 1, 32'hFFFFFFFC, 5'd31, 0));
      idle(3);
      check_eq("sb_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
